// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receive controller: one write per rising ready, parity-errored bytes dropped.
// Optional parity-error counter and err_cnt port enabled by `define UART_RX_FIFO_ERRCNT_EN.
module uart_rx_fifo #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_error,
    input  logic              rd_en,
    input  logic              stat_clr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef UART_RX_FIFO_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;

    logic             rdy_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       mem_q [DEPTH];

    logic             frame_ev;
    logic             pop;
    logic             push;
    logic             ovf_set;
    logic [PTR_W-1:0] count_c;

    // Occupancy derived from registered pointers only.
    assign count_c = wr_ptr_q - rd_ptr_q;
    assign count   = count_c;
    assign empty   = (count_c == '0);
    assign full    = (count_c == PTR_W'(DEPTH));

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = overflow_q;

    // Push/pop decisions and next-state for pointers, read port and overflow flag.
    always_comb begin
        frame_ev   = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        ovf_set    = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;

        frame_ev = rx_ready & ~rdy_q;
        pop      = rd_en & ~empty;
        push     = frame_ev & ~rx_error & (~full | pop);
        ovf_set  = frame_ev & ~rx_error & full & ~pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end
        if (stat_clr) begin
            overflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
    end

    // rdy_q resets high so a ready level present at reset release is not a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rdy_q      <= rx_ready;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
        end
    end

`ifdef UART_RX_FIFO_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_set;

    // Saturating parity-error counter; a same-cycle error beats stat_clr.
    always_comb begin
        err_set   = rx_ready & ~rdy_q & rx_error;
        err_cnt_d = err_cnt_q;
        if (stat_clr) begin
            err_cnt_d = 8'h00;
        end
        if (err_set) begin
            if (stat_clr) begin
                err_cnt_d = 8'h01;
            end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'h01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo, built with ADDR_W=2 (depth 4).
module tb_uart_rx_fifo;

    localparam int unsigned ADDR_W = 2;

    logic            clk;
    logic            rst_n;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            rx_error;
    logic            rd_en;
    logic            stat_clr;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overflow;
`ifdef UART_RX_FIFO_ERRCNT_EN
    logic [7:0]      err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rx_error (rx_error),
        .rd_en    (rd_en),
        .stat_clr (stat_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef UART_RX_FIFO_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One UART frame: ready rises for one edge, then drops.
    task automatic send_frame(input logic [7:0] d, input logic e, input logic clr);
        @(negedge clk);
        rx_data  = d;
        rx_error = e;
        rx_ready = 1'b1;
        stat_clr = clr;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        stat_clr = 1'b0;
    endtask

    task automatic do_pop(output logic [7:0] d, output logic v);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_ready = 1'b1; rx_data = 8'h5A; rx_error = 1'b0;
        rd_en = 1'b0; stat_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({count, empty, full, rd_valid, rd_data, overflow} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b vld=%b data=%h ovf=%b, expected 0 1 0 0 00 0",
                     count, empty, full, rd_valid, rd_data, overflow);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_high: count=%0d empty=%b, expected 0 1", count, empty);
        end
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL ready_fall: count=%0d, expected 0", count);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] exp_d [3];
        exp_d = '{8'hA5, 8'h3C, 8'hFF};
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3 || empty !== 1'b0) begin
            errors++;
            $display("FAIL order_count: count=%0d empty=%b, expected 3 0", count, empty);
        end
        @(negedge clk);
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) rd_en = 1'b0;
            checks++;
            if (rd_data !== exp_d[i] || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL order_read%0d: data=%h vld=%b, expected %h 1", i, rd_data, rd_valid, exp_d[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'hFF) begin
            errors++;
            $display("FAIL order_drained: empty=%b vld=%b data=%h, expected 1 0 ff", empty, rd_valid, rd_data);
        end
    endtask

    task automatic test_parity_error();
        logic [7:0] d;
        logic       v;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL perr_count: count=%0d, expected 2", count);
        end
`ifdef UART_RX_FIFO_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL perr_errcnt: err_cnt=%0d, expected 1", err_cnt);
        end
`endif
        do_pop(d, v);
        checks++;
        if (d !== 8'h11 || v !== 1'b1) begin
            errors++;
            $display("FAIL perr_read0: data=%h vld=%b, expected 11 1", d, v);
        end
        do_pop(d, v);
        checks++;
        if (d !== 8'h33 || v !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL perr_read1: data=%h vld=%b empty=%b, expected 33 1 1", d, v, empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       v;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_state: full=%b count=%0d ovf=%b, expected 1 4 1", full, count, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            do_pop(d, v);
            checks++;
            if (d !== 8'(i) || v !== 1'b1) begin
                errors++;
                $display("FAIL ovf_read%0d: data=%h vld=%b, expected %h 1", i, d, v, 8'(i));
            end
        end
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b empty=%b, expected 0 1", overflow, empty);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] d;
        logic       v;
        logic [7:0] exp_d [4];
        exp_d = '{8'hA1, 8'hA2, 8'hA3, 8'h77};
        for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b0);
        @(negedge clk);
        rx_data = 8'h77; rx_ready = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0; rd_en = 1'b0;
        checks++;
        if (rd_data !== 8'hA0 || rd_valid !== 1'b1 || count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL pp_full: data=%h vld=%b count=%0d ovf=%b full=%b, expected a0 1 4 0 1",
                     rd_data, rd_valid, count, overflow, full);
        end
        for (int i = 0; i < 4; i++) begin
            do_pop(d, v);
            checks++;
            if (d !== exp_d[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL pp_drain%0d: data=%h vld=%b, expected %h 1", i, d, v, exp_d[i]);
            end
        end
    endtask

    task automatic test_clr_race();
        for (int i = 0; i < 4; i++) send_frame(8'hB0 + 8'(i), 1'b0, 1'b0);
        send_frame(8'hB4, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd4) begin
            errors++;
            $display("FAIL race_ovf: ovf=%b count=%0d, expected 1 4", overflow, count);
        end
`ifdef UART_RX_FIFO_ERRCNT_EN
        send_frame(8'hE1, 1'b1, 1'b0);
        send_frame(8'hE1, 1'b1, 1'b0);
        checks++;
        if (err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL race_errcnt_pre: err_cnt=%0d, expected 2", err_cnt);
        end
        send_frame(8'hE2, 1'b1, 1'b1);
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL race_errcnt: err_cnt=%0d, expected 1", err_cnt);
        end
`endif
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        logic       v;
        do_pop(d, v);
        do_pop(d, v);
        checks++;
        if (count !== 3'd2 || d !== 8'hB1) begin
            errors++;
            $display("FAIL mid_pre: count=%0d data=%h, expected 2 b1", count, d);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_data !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: count=%0d empty=%b data=%h ovf=%b, expected 0 1 00 0",
                     count, empty, rd_data, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== 3'd0) begin
                errors++;
                $display("FAIL mid_read%0d: empty=%b vld=%b data=%h count=%0d, expected 1 0 00 0",
                         i, empty, rd_valid, rd_data, count);
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_parity_error();
        test_overflow();
        test_push_pop_full();
        test_clr_race();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
